// File: rtl/dspdbg_capctl_if.sv
// Signal bundle between the DSP sample path, debug control registers and the ILA probe stub.
// The slave modport is the capture controller; the master modport is whatever drives it.
interface dspdbg_capctl_if #(
   parameter int unsigned DW   = 16,
   parameter int unsigned NCH  = 3,
   parameter int unsigned CNTW = 13,
   parameter int unsigned TSW  = 64
);
   logic [NCH*DW-1:0] din;
   logic              din_valid;
   logic              arm;
   logic              abort;
   logic              rearm;
   logic              sw_trig;
   logic [1:0]        trig_sel;
   logic [DW-1:0]     thresh;
   logic [CNTW-1:0]   win_len;
   logic [CNTW-1:0]   holdoff;
   logic [NCH*DW-1:0] dout;
   logic              dout_valid;
   logic              cap_en;
   logic [1:0]        state;
   logic [CNTW-1:0]   win_cnt;
   logic [TSW-1:0]    ts;
   logic [TSW-1:0]    trig_ts;

   modport master (
      output din, din_valid, arm, abort, rearm, sw_trig, trig_sel, thresh, win_len, holdoff,
      input  dout, dout_valid, cap_en, state, win_cnt, ts, trig_ts
   );

   modport slave (
      input  din, din_valid, arm, abort, rearm, sw_trig, trig_sel, thresh, win_len, holdoff,
      output dout, dout_valid, cap_en, state, win_cnt, ts, trig_ts
   );
endinterface

// File: rtl/dspdbg_capctl.sv
// Debug capture controller ahead of the DSP ILA stub: 2-stage sample pipe, trigger FSM, window.
// Define DSPDBG_TS_EN to build the free-running timestamp and trigger timestamp latch.
module dspdbg_capctl #(
   parameter int unsigned DW   = 16,
   parameter int unsigned NCH  = 3,
   parameter int unsigned CNTW = 13,
   parameter int unsigned TSW  = 64
) (
   input logic            clk,
   input logic            rstn,
   dspdbg_capctl_if.slave bus
);
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StHoldoff = 2'd3
   } state_e;

   localparam logic [DW-1:0]   SMin = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0]   SMax = {1'b0, {(DW-1){1'b1}}};
   localparam logic [CNTW-1:0] One  = CNTW'(1);

   state_e                state_q;
   logic [NCH*DW-1:0]     s1_data_q, s2_data_q;
   logic                  s1_valid_q, s2_valid_q, s1_sw_q;
   logic signed [DW-1:0]  prev_q;
   logic [CNTW-1:0]       win_cnt_q, win_len_q, hold_cnt_q, holdoff_q;

   logic signed [DW-1:0]  cur, thr, cur_mag;
   logic                  hit, trig, cap_en;

   always_comb begin
      cur = s1_data_q[DW-1:0];
      thr = bus.thresh;
      // Most negative sample has no positive twin; clamp its magnitude.
      if (cur == SMin)     cur_mag = SMax;
      else if (cur[DW-1])  cur_mag = -cur;
      else                 cur_mag = cur;
      unique case (bus.trig_sel)
         2'd0:    hit = 1'b0;
         2'd1:    hit = (prev_q < thr) && (cur >= thr);
         2'd2:    hit = (prev_q >= thr) && (cur < thr);
         default: hit = (cur_mag >= thr);
      endcase
      trig   = s1_valid_q && (state_q == StArmed) && (s1_sw_q || hit);
      cap_en = (state_q == StCapture) && s2_valid_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         s1_data_q  <= '0;
         s2_data_q  <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_sw_q    <= 1'b0;
         prev_q     <= '0;
         win_cnt_q  <= '0;
         win_len_q  <= '0;
         hold_cnt_q <= '0;
         holdoff_q  <= '0;
      end else begin
         s1_data_q  <= bus.din;
         s1_valid_q <= bus.din_valid;
         s1_sw_q    <= bus.sw_trig;
         s2_data_q  <= s1_data_q;
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) prev_q <= cur;

         if (bus.abort) begin
            state_q <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.arm) state_q <= StArmed;
               end
               StArmed: begin
                  if (trig) begin
                     state_q   <= StCapture;
                     win_cnt_q <= '0;
                     win_len_q <= bus.win_len;
                  end
               end
               StCapture: begin
                  if (cap_en) begin
                     if (win_cnt_q == win_len_q) begin
                        holdoff_q  <= bus.holdoff;
                        hold_cnt_q <= '0;
                        if (bus.holdoff == '0) state_q <= bus.rearm ? StArmed : StIdle;
                        else                   state_q <= StHoldoff;
                     end else begin
                        win_cnt_q <= win_cnt_q + One;
                     end
                  end
               end
               StHoldoff: begin
                  if (hold_cnt_q == holdoff_q - One) state_q <= bus.rearm ? StArmed : StIdle;
                  else                               hold_cnt_q <= hold_cnt_q + One;
               end
            endcase
         end
      end
   end

   assign bus.dout       = s2_data_q;
   assign bus.dout_valid = s2_valid_q;
   assign bus.cap_en     = cap_en;
   assign bus.state      = state_q;
   assign bus.win_cnt    = win_cnt_q;

`ifdef DSPDBG_TS_EN
   logic [TSW-1:0] ts_q, trig_ts_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ts_q      <= '0;
         trig_ts_q <= '0;
      end else begin
         ts_q <= ts_q + TSW'(1);
         if (trig && !bus.abort) trig_ts_q <= ts_q;
      end
   end

   assign bus.ts      = ts_q;
   assign bus.trig_ts = trig_ts_q;
`else
   assign bus.ts      = {TSW{1'b0}};
   assign bus.trig_ts = {TSW{1'b0}};
`endif
endmodule

// File: doc/dspdbg_capctl.md
Name: dspdbg_capctl

Overview:
- Debug capture controller that sits directly upstream of the DSP integrated logic analyser (ILA) probe stub in the zcu216 top.
- Registers up to three 16-bit DSP sample streams and detects a trigger: software strobe, level crossing or magnitude threshold.
- Drives a qualified capture-enable window, FSM state, window counter and cycle timestamp to the ILA probes.
- Lets the ILA store-qualify on a deterministic, software-programmed window.

Parameters:
- DW, 16, sample width (signed, two's complement)
- NCH, 3, number of sample channels packed on din/dout
- CNTW, 13, width of window length, holdoff and window counter
- TSW, 64, timestamp width

Ports:
- clk  in  1  DSP clock
- rstn  in  1  asynchronous active-low reset
- din  in  NCH*DW  packed samples; channel 0 in LSBs
- din_valid  in  1  sample qualifier
- arm  in  1  single-cycle pulse; IDLE->ARMED
- abort  in  1  single-cycle pulse; any state->IDLE
- rearm  in  1  level; auto re-arm after holdoff
- sw_trig  in  1  single-cycle software trigger pulse
- trig_sel  in  2  0 sw only, 1 rising crossing ch0, 2 falling crossing ch0, 3 |ch0|>=thresh
- thresh  in  DW  signed threshold
- win_len  in  CNTW  capture length minus one, in valid samples
- holdoff  in  CNTW  holdoff length in clk cycles
- dout  out  NCH*DW  samples delayed two cycles
- dout_valid  out  1  din_valid delayed two cycles
- cap_en  out  1  ILA store qualifier
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 HOLDOFF
- win_cnt  out  CNTW  samples captured in the current window
- ts  out  TSW  free-running cycle counter
- trig_ts  out  TSW  ts value latched at trigger

Behaviour:
- Reset: all outputs 0; state IDLE; the stored previous-sample register is 0.
- Pipeline: din/din_valid are registered into stage1 at t+1 and into stage2 (dout/dout_valid) at t+2. Fixed latency of 2 cycles for every sample.
- Trigger evaluation is combinational on stage1 and only happens when stage1 valid=1 and state=ARMED. Comparisons use cur = stage1 channel 0 and prev = last valid channel-0 sample.
  - sw_trig: a pulse registered into stage1 alongside the data; always a trigger source in every trig_sel mode.
  - Mode 1: prev<thresh and cur>=thresh.
  - Mode 2: prev>=thresh and cur<thresh.
  - Mode 3: |cur|>=thresh. |-2^(DW-1)| saturates to 2^(DW-1)-1.
- A trigger hit at the end of cycle t+1 moves state to CAPTURE, loads win_cnt=0 and latches trig_ts=ts. The triggering sample appears on dout at t+2 with cap_en=1.
- cap_en = (state==CAPTURE) & dout_valid.
- CAPTURE: win_cnt increments on each cycle with cap_en=1. When cap_en=1 and win_cnt==win_len, the next state is HOLDOFF (or the rearm target when holdoff==0).
  - Exactly win_len+1 samples get cap_en=1. win_len=0 yields one sample.
  - dout_valid gaps extend the window and do not count.
- HOLDOFF: counts holdoff clk cycles, then goes to ARMED if rearm=1, else IDLE.
  - The prev register keeps tracking valid samples during HOLDOFF.
  - Triggers during HOLDOFF are ignored.
- IDLE->ARMED on arm. arm is ignored in any other state.
- abort forces IDLE on the next edge from any state; cap_en falls the same edge. abort wins over simultaneous arm, trigger or window end.
- win_len and holdoff are sampled at trigger and at HOLDOFF entry respectively. Mid-window changes have no effect.
- ts increments every cycle and wraps modulo 2^TSW.
- win_cnt holds its final value in HOLDOFF, ARMED and IDLE until the next trigger.

Optional Feature:
- DSPDBG_TS_EN defined: ts counter and trig_ts latch are present as described.
- Not defined: ts and trig_ts are tied to 0, and no counter logic is synthesised. Everything else is unchanged.

Test Plan:
- Reset then arm, trig_sel=0, sw_trig at cycle 10 with din_valid=1, win_len=4 -> cap_en high cycles 12..16 (5 samples); win_cnt 0..4; state CAPTURE then HOLDOFF.
- trig_sel=1, thresh=100, ch0 ramp 90,95,100,105 -> the first captured dout ch0 is 100; trig_ts equals ts at the edge where CAPTURE is entered.
- trig_sel=3, thresh=0x7FFF, ch0=0x8000 -> triggers (saturated magnitude); thresh=0x7FFF, ch0=0x7FFE -> no trigger.
- din_valid toggled 1,0,1,0 during CAPTURE with win_len=3 -> 4 cap_en pulses spread over 7 cycles; no pulse on invalid cycles.
- rearm=1, holdoff=8 -> HOLDOFF lasts 8 cycles, then ARMED. A second crossing inside holdoff is ignored; one after holdoff retriggers.
- abort asserted with arm in the same cycle during CAPTURE -> state IDLE next edge, cap_en 0. Async rstn drop mid-window clears all outputs immediately.
